// File: rtl/find_left_right.sv
// Horizontal-extent search for one star: walks the frame ROM left, then right,
// along the star's middle row, starting from the supplied start column.
module find_left_right #(
   parameter int              xSz       = 8,
   parameter int              ySz       = 7,
   parameter int              addrSz    = 15,
   parameter int              colSz     = 3,
   parameter logic [xSz-1:0]  X_MAX     = 8'd159,
   parameter int              THRESHOLD = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              TopandBottomFound,
   input  logic [ySz-1:0]    mostTop,
   input  logic [ySz-1:0]    mostBottom,
   input  logic [xSz-1:0]    midPix,
   output logic [addrSz-1:0] memAddr,
   input  logic [colSz-1:0]  memQ,
   output logic [xSz-1:0]    mostLeft,
   output logic [xSz-1:0]    mostRight,
   output logic [ySz-1:0]    midRow,
   output logic [xSz-1:0]    midCol,
   output logic              busy,
   output logic              LeftandRightFound
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LATCH   = 3'd1;
   localparam logic [2:0] L_ISSUE = 3'd2;
   localparam logic [2:0] L_CHECK = 3'd3;
   localparam logic [2:0] R_ISSUE = 3'd4;
   localparam logic [2:0] R_CHECK = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;

   localparam logic [colSz-1:0]  THR        = colSz'(THRESHOLD);
   localparam logic [addrSz-1:0] ROW_STRIDE = addrSz'(X_MAX) + addrSz'(1);

   logic [2:0]     state, state_nxt;
   logic [xSz-1:0] x_cur, x_nxt;
   logic [ySz-1:0] top_q, top_nxt, bot_q, bot_nxt, row_q, row_nxt;
   logic [xSz-1:0] pix_q, pix_nxt;
   logic [xSz-1:0] left_q, left_nxt, right_q, right_nxt, col_q, col_nxt;
   logic [ySz:0]   row_sum;
   logic [xSz:0]   col_sum;
   logic           bright, start_right;

   assign bright = memQ > THR;

   // Next-state and datapath; boundary tests come before any step so x never wraps.
   always_comb begin
      state_nxt   = state;
      x_nxt       = x_cur;
      top_nxt     = top_q;
      bot_nxt     = bot_q;
      pix_nxt     = pix_q;
      row_nxt     = row_q;
      left_nxt    = left_q;
      right_nxt   = right_q;
      col_nxt     = col_q;
      start_right = 1'b0;
      row_sum     = {1'b0, top_q} + {1'b0, bot_q};
      col_sum     = '0;
      case (state)
         IDLE: begin
            if (TopandBottomFound) begin
               top_nxt   = mostTop;
               bot_nxt   = mostBottom;
               pix_nxt   = midPix;
               state_nxt = LATCH;
            end
         end
         LATCH: begin
            row_nxt   = (bot_q < top_q) ? top_q : row_sum[ySz:1];
            x_nxt     = pix_q;
            state_nxt = L_ISSUE;
         end
         L_ISSUE: state_nxt = L_CHECK;
         L_CHECK: begin
            if (!bright) begin
               if (x_cur == pix_q) begin
                  left_nxt  = pix_q;
                  right_nxt = pix_q;
                  state_nxt = DONE;
               end else begin
                  left_nxt    = x_cur + 1'b1;
                  start_right = 1'b1;
               end
            end else if (x_cur == '0) begin
               left_nxt    = '0;
               start_right = 1'b1;
            end else begin
               x_nxt     = x_cur - 1'b1;
               state_nxt = L_ISSUE;
            end
         end
         R_ISSUE: state_nxt = R_CHECK;
         R_CHECK: begin
            if (!bright) begin
               right_nxt = x_cur - 1'b1;
               state_nxt = DONE;
            end else if (x_cur == X_MAX) begin
               right_nxt = X_MAX;
               state_nxt = DONE;
            end else begin
               x_nxt     = x_cur + 1'b1;
               state_nxt = R_ISSUE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (start_right) begin
         if (pix_q == X_MAX) begin
            right_nxt = X_MAX;
            state_nxt = DONE;
         end else begin
            x_nxt     = pix_q + 1'b1;
            state_nxt = R_ISSUE;
         end
      end

      // The centre is captured on entry to DONE so it is valid alongside the pulse.
      if (state_nxt == DONE && state != DONE) begin
         col_sum = {1'b0, left_nxt} + {1'b0, right_nxt};
         col_nxt = col_sum[xSz:1];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         x_cur   <= '0;
         top_q   <= '0;
         bot_q   <= '0;
         pix_q   <= '0;
         row_q   <= '0;
         left_q  <= '0;
         right_q <= '0;
         col_q   <= '0;
      end else begin
         state   <= state_nxt;
         x_cur   <= x_nxt;
         top_q   <= top_nxt;
         bot_q   <= bot_nxt;
         pix_q   <= pix_nxt;
         row_q   <= row_nxt;
         left_q  <= left_nxt;
         right_q <= right_nxt;
         col_q   <= col_nxt;
      end
   end

   assign memAddr           = addrSz'(row_q) * ROW_STRIDE + addrSz'(x_cur);
   assign mostLeft          = left_q;
   assign mostRight         = right_q;
   assign midRow            = row_q;
   assign midCol            = col_q;
   assign busy              = (state != IDLE);
   assign LeftandRightFound = (state == DONE);

endmodule

// File: tb/tb_find_left_right.sv
// Directed and randomized checks of find_left_right against a frame-walking
// reference model and a synchronous ROM built from a random frame.
module tb_find_left_right;

   localparam int W = 160;
   localparam int H = 120;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        TopandBottomFound = 1'b0;
   logic [6:0]  mostTop = '0;
   logic [6:0]  mostBottom = '0;
   logic [7:0]  midPix = '0;
   logic [14:0] memAddr;
   logic [2:0]  memQ = '0;
   logic [7:0]  mostLeft, mostRight, midCol;
   logic [6:0]  midRow;
   logic        busy, LeftandRightFound;

   logic [2:0]  frame [0:W*H-1];
   int          total = 0;
   int          bad = 0;

   find_left_right dut (
      .clk(clk), .resetn(resetn), .TopandBottomFound(TopandBottomFound),
      .mostTop(mostTop), .mostBottom(mostBottom), .midPix(midPix),
      .memAddr(memAddr), .memQ(memQ), .mostLeft(mostLeft), .mostRight(mostRight),
      .midRow(midRow), .midCol(midCol), .busy(busy), .LeftandRightFound(LeftandRightFound)
   );

   always #5 clk = ~clk;

   always @(posedge clk) memQ <= frame[memAddr];

   function automatic logic [14:0] idx(input int row, input int x);
      return 15'(row * W + x);
   endfunction

   function automatic bit isBright(input int row, input int x);
      return frame[idx(row, x)] > 3'd0;
   endfunction

   // Reference: extent of the bright run through mid, number of ROM probes, furthest probe.
   function automatic void refScan(input int row, input int mid, output int l, output int r,
                                   output int probes, output int max_probe);
      if (!isBright(row, mid)) begin
         l = mid; r = mid; probes = 1; max_probe = mid;
         return;
      end
      l = mid;
      while (l > 0 && isBright(row, l - 1)) l--;
      probes = (mid - l + 1) + ((l > 0) ? 1 : 0);
      if (mid == W - 1) begin
         r = W - 1;
         max_probe = mid;
      end else begin
         r = mid;
         while (r < W - 1 && isBright(row, r + 1)) r++;
         probes += (r - mid) + ((r < W - 1) ? 1 : 0);
         max_probe = (r < W - 1) ? r + 1 : W - 1;
      end
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic setRow(input int row, input int lo, input int hi);
      for (int x = 0; x < W; x++)
         frame[idx(row, x)] = (x >= lo && x <= hi) ? 3'($urandom_range(1, 7)) : 3'd0;
   endtask

   // One job: pulse, follow the scan cycle by cycle, then compare with the model.
   task automatic applyStimulus(input int top, input int bottom, input int mid, input bit retrig);
      int row, l, r, n, maxp, k, pulse_k, max_x, x, extra;
      row = (bottom < top) ? top : (top + bottom) / 2;
      refScan(row, mid, l, r, n, maxp);
      @(negedge clk);
      mostTop = 7'(top); mostBottom = 7'(bottom); midPix = 8'(mid);
      TopandBottomFound = 1'b1;
      @(negedge clk);
      TopandBottomFound = 1'b0;
      mostTop = 7'($urandom_range(0, H - 1));
      mostBottom = 7'($urandom_range(0, H - 1));
      midPix = 8'($urandom_range(0, W - 1));
      checkOutput("busy_rise", int'(busy), 1);
      k = 1; pulse_k = 0; max_x = -1;
      while (pulse_k == 0 && k < 1000) begin
         if (k == 2) checkOutput("first_addr", int'(memAddr), row * W + mid);
         if (k >= 2) begin
            x = int'(memAddr) - row * W;
            if (x > max_x) max_x = x;
         end
         if (retrig && k == 3) begin
            mostTop = 7'd5; mostBottom = 7'd9; midPix = 8'd100;
            TopandBottomFound = 1'b1;
         end
         if (retrig && k == 4) TopandBottomFound = 1'b0;
         if (LeftandRightFound) pulse_k = k;
         else begin
            @(negedge clk);
            k++;
         end
      end
      TopandBottomFound = 1'b0;
      checkOutput("done_cycle", pulse_k, 2 + 2 * n);
      checkOutput("midRow", int'(midRow), row);
      checkOutput("mostLeft", int'(mostLeft), l);
      checkOutput("mostRight", int'(mostRight), r);
      checkOutput("midCol", int'(midCol), (l + r) / 2);
      checkOutput("max_probe_x", max_x, maxp);
      @(negedge clk);
      checkOutput("pulse_width", int'(LeftandRightFound), 0);
      checkOutput("busy_fall", int'(busy), 0);
      checkOutput("hold_left", int'(mostLeft), l);
      if (retrig) begin
         extra = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (LeftandRightFound || busy) extra++;
         end
         checkOutput("retrig_ignored", extra, 0);
      end
   endtask

   initial begin
      int pulses, top, bottom, mid, row;
      for (int i = 0; i < W * H; i++) frame[i] = 3'($urandom_range(0, 7));

      #1;
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_pulse", int'(LeftandRightFound), 0);
      checkOutput("reset_addr", int'(memAddr), 0);
      checkOutput("reset_left", int'(mostLeft), 0);
      checkOutput("reset_row", int'(midRow), 0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;

      $display("[TB] normal star");
      setRow(30, 45, 55);
      applyStimulus(25, 35, 50, 1'b0);

      $display("[TB] left boundary");
      setRow(15, 0, 4);
      applyStimulus(10, 20, 2, 1'b0);

      $display("[TB] right boundary");
      setRow(60, 150, 159);
      applyStimulus(60, 60, 159, 1'b0);

      $display("[TB] dark start, bottom above top");
      setRow(100, 10, 30);
      frame[idx(100, 20)] = 3'd0;
      applyStimulus(100, 80, 20, 1'b0);

      $display("[TB] full bright row from the last column");
      setRow(119, 0, 159);
      applyStimulus(119, 119, 159, 1'b0);

      $display("[TB] ignored retrigger");
      setRow(30, 45, 55);
      applyStimulus(25, 35, 50, 1'b1);

      $display("[TB] randomized jobs");
      for (int j = 0; j < 10; j++) begin
         top = $urandom_range(0, H - 1);
         bottom = $urandom_range(0, H - 1);
         mid = $urandom_range(0, W - 1);
         row = (bottom < top) ? top : (top + bottom) / 2;
         for (int x = 0; x < W; x++)
            frame[idx(row, x)] = ($urandom_range(0, 5) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         applyStimulus(top, bottom, mid, 1'b0);
      end

      $display("[TB] reset during right scan");
      setRow(30, 45, 55);
      @(negedge clk);
      mostTop = 7'd25; mostBottom = 7'd35; midPix = 8'd50;
      TopandBottomFound = 1'b1;
      @(negedge clk);
      TopandBottomFound = 1'b0;
      for (int i = 1; i < 18; i++) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_left", int'(mostLeft), 0);
      checkOutput("abort_right", int'(mostRight), 0);
      checkOutput("abort_row", int'(midRow), 0);
      checkOutput("abort_col", int'(midCol), 0);
      checkOutput("abort_addr", int'(memAddr), 0);
      @(negedge clk);
      resetn = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (LeftandRightFound) pulses++;
      end
      checkOutput("abort_no_pulse", pulses, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
